// File: rtl/vga_scanout.sv
// VGA raster timing and pixel output stage sitting downstream of the sprite cluster.
// Define VGA_TEST_PATTERN_EN to add the test_en input and an 8-bar colour test pattern.
module vga_scanout #(
  parameter int H_ACTIVE      = 640,
  parameter int H_FP          = 16,
  parameter int H_SYNC        = 96,
  parameter int H_BP          = 48,
  parameter int V_ACTIVE      = 480,
  parameter int V_FP          = 10,
  parameter int V_SYNC        = 2,
  parameter int V_BP          = 33,
  parameter int CLK_DIV       = 4,
  parameter int PIXEL_LATENCY = 1,
  parameter int INT_WIDTH     = 16,
  parameter int COLOR_WIDTH   = 12
) (
  input  logic                   clk,
  input  logic                   rst,
`ifdef VGA_TEST_PATTERN_EN
  input  logic                   test_en,
`endif
  output logic [INT_WIDTH-1:0]   x,
  output logic [INT_WIDTH-1:0]   y,
  input  logic [COLOR_WIDTH-1:0] pixel,
  output logic [3:0]             vga_r,
  output logic [3:0]             vga_g,
  output logic [3:0]             vga_b,
  output logic                   hsync,
  output logic                   vsync,
  output logic                   frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int PW      = $clog2(CLK_DIV);

  localparam logic [HW-1:0] H_ACT_END = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_START  = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END    = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT_END = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_START  = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END    = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VW-1:0] V_LAST    = VW'(V_TOTAL - 1);
  localparam logic [PW-1:0] P_LAST    = PW'(CLK_DIV - 1);

  // Sideband word delayed alongside the cluster latency: {[bar colour,] active, hs_n, vs_n}
`ifdef VGA_TEST_PATTERN_EN
  localparam int SB_W = 3 + COLOR_WIDTH;
`else
  localparam int SB_W = 3;
`endif
  localparam logic [SB_W-1:0] SB_IDLE = SB_W'(3'b011);

  logic [PW-1:0]          prescaler;
  logic [HW-1:0]          hcnt;
  logic [VW-1:0]          vcnt;
  logic                   tick;
  logic                   h_wrap;
  logic                   v_wrap;
  logic                   active_raw;
  logic                   hs_raw;
  logic                   vs_raw;
  logic [SB_W-1:0]        raw_sb;
  logic [SB_W-1:0]        tap_sb;
  logic [COLOR_WIDTH-1:0] colour;

`ifdef VGA_TEST_PATTERN_EN
  function automatic logic [COLOR_WIDTH-1:0] bar_color(input logic [2:0] idx);
    case (idx)
      3'd0:    bar_color = COLOR_WIDTH'(12'hFFF);
      3'd1:    bar_color = COLOR_WIDTH'(12'hFF0);
      3'd2:    bar_color = COLOR_WIDTH'(12'h0FF);
      3'd3:    bar_color = COLOR_WIDTH'(12'h0F0);
      3'd4:    bar_color = COLOR_WIDTH'(12'hF0F);
      3'd5:    bar_color = COLOR_WIDTH'(12'hF00);
      3'd6:    bar_color = COLOR_WIDTH'(12'h00F);
      default: bar_color = COLOR_WIDTH'(12'h000);
    endcase
  endfunction
`endif

  assign tick   = (prescaler == P_LAST);
  assign h_wrap = (hcnt == H_LAST);
  assign v_wrap = (vcnt == V_LAST);
  assign x      = INT_WIDTH'(hcnt);
  assign y      = INT_WIDTH'(vcnt);

  // Prescaler, raster counters and the frame_start pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      prescaler   <= {PW{1'b0}};
      hcnt        <= {HW{1'b0}};
      vcnt        <= {VW{1'b0}};
      frame_start <= 1'b0;
    end else begin
      prescaler   <= tick ? {PW{1'b0}} : prescaler + PW'(1);
      frame_start <= tick && h_wrap && v_wrap;
      if (tick) begin
        hcnt <= h_wrap ? {HW{1'b0}} : hcnt + HW'(1);
        if (h_wrap) begin
          vcnt <= v_wrap ? {VW{1'b0}} : vcnt + VW'(1);
        end
      end
    end
  end

  // Raw per-coordinate blanking and sync state
  always_comb begin
    active_raw = (hcnt < H_ACT_END) && (vcnt < V_ACT_END);
    hs_raw     = !((hcnt >= HS_START) && (hcnt < HS_END));
    vs_raw     = !((vcnt >= VS_START) && (vcnt < VS_END));
  end

`ifdef VGA_TEST_PATTERN_EN
  assign raw_sb = {bar_color(x[9:7]), active_raw, hs_raw, vs_raw};
`else
  assign raw_sb = {active_raw, hs_raw, vs_raw};
`endif

  // The output register is the last latency stage, so only PIXEL_LATENCY-1 extra stages exist
  generate
    if (PIXEL_LATENCY == 1) begin : g_no_delay
      assign tap_sb = raw_sb;
    end else begin : g_delay
      logic [SB_W-1:0] sb_sr [PIXEL_LATENCY-1];

      // Sideband delay line advanced once per pixel tick
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < PIXEL_LATENCY - 1; i++) begin
            sb_sr[i] <= SB_IDLE;
          end
        end else if (tick) begin
          sb_sr[0] <= raw_sb;
          for (int i = 1; i < PIXEL_LATENCY - 1; i++) begin
            sb_sr[i] <= sb_sr[i-1];
          end
        end
      end

      assign tap_sb = sb_sr[PIXEL_LATENCY-2];
    end
  endgenerate

  // Colour source: cluster pixel, or the delayed bar colour in test mode
  always_comb begin
`ifdef VGA_TEST_PATTERN_EN
    if (test_en) begin
      colour = tap_sb[SB_W-1:3];
    end else begin
      colour = pixel;
    end
`else
    colour = pixel;
`endif
  end

  // VGA pin register, updated once per pixel tick
  always_ff @(posedge clk) begin
    if (rst) begin
      vga_r <= 4'h0;
      vga_g <= 4'h0;
      vga_b <= 4'h0;
      hsync <= 1'b1;
      vsync <= 1'b1;
    end else if (tick) begin
      {vga_r, vga_g, vga_b} <= tap_sb[2] ? colour : {COLOR_WIDTH{1'b0}};
      hsync                 <= tap_sb[1];
      vsync                 <= tap_sb[0];
    end
  end

endmodule

// File: tb/tb_vga_scanout.sv
// Directed bench for vga_scanout: full horizontal timing, shortened vertical timing, latency 2.
module tb_vga_scanout;

  localparam int CLK_DIV    = 4;
  localparam int H_ACTIVE   = 640;
  localparam int H_TOTAL    = 800;
  localparam int V_ACTIVE   = 1;
  localparam int V_FP       = 1;
  localparam int V_SYNC     = 2;
  localparam int V_BP       = 1;
  localparam int V_TOTAL    = 5;
  localparam int LAT        = 2;
  localparam int LINE_CLKS  = 3200;
  localparam int FRAME_CLKS = 16000;

  logic        clk;
  logic        rst;
  logic [15:0] x;
  logic [15:0] y;
  logic [11:0] pixel;
  logic [3:0]  vga_r;
  logic [3:0]  vga_g;
  logic [3:0]  vga_b;
  logic        hsync;
  logic        vsync;
  logic        frame_start;
`ifdef VGA_TEST_PATTERN_EN
  logic        test_en;
`endif

  int          checks   = 0;
  int          failures = 0;
  int unsigned cyc      = 0;

  vga_scanout #(
    .H_ACTIVE(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .CLK_DIV(CLK_DIV), .PIXEL_LATENCY(LAT), .INT_WIDTH(16), .COLOR_WIDTH(12)
  ) dut (
    .clk(clk),
    .rst(rst),
`ifdef VGA_TEST_PATTERN_EN
    .test_en(test_en),
`endif
    .x(x),
    .y(y),
    .pixel(pixel),
    .vga_r(vga_r),
    .vga_g(vga_g),
    .vga_b(vga_b),
    .hsync(hsync),
    .vsync(vsync),
    .frame_start(frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Cluster model: colour for a coordinate becomes valid LAT ticks after it is presented
  logic [15:0] mx1 = '0, my1 = '0, mx2 = '0, my2 = '0, lx = '0, ly = '0;
  always @(negedge clk) begin
    if (x !== lx || y !== ly) begin
      mx2 = mx1; my2 = my1;
      mx1 = x;   my1 = y;
      lx  = x;   ly  = y;
    end
    pixel = {mx2[3:0], my2[3:0], 4'hA};
  end

  task automatic wait_xy(input int wx, input int wy, input int max_clk, output bit ok);
    ok = (x == wx && y == wy);
    for (int i = 0; i < max_clk && !ok; i++) begin
      @(negedge clk);
      ok = (x == wx && y == wy);
    end
  endtask

  task automatic test_reset();
    int n;
    rst = 1'b1;
    repeat (5) @(negedge clk);
    checks++; if (x !== 16'd0 || y !== 16'd0) begin failures++; $display("FAIL reset_xy: got x=%0d y=%0d expected 0 0", x, y); end
    checks++; if (hsync !== 1'b1 || vsync !== 1'b1) begin failures++; $display("FAIL reset_sync: got hs=%b vs=%b expected 1 1", hsync, vsync); end
    checks++; if ({vga_r, vga_g, vga_b} !== 12'h000) begin failures++; $display("FAIL reset_rgb: got %h expected 000", {vga_r, vga_g, vga_b}); end
    checks++; if (frame_start !== 1'b0) begin failures++; $display("FAIL reset_frame_start: got %b expected 0", frame_start); end
    rst = 1'b0;
    n = 0;
    for (int i = 0; i < 20 && x !== 16'd1; i++) begin
      @(negedge clk);
      n++;
    end
    checks++; if (n != CLK_DIV || x !== 16'd1) begin failures++; $display("FAIL first_tick: got x=1 after %0d clocks (x=%0d) expected after %0d", n, x, CLK_DIV); end
  endtask

  task automatic test_color_align();
    logic [15:0] px, py, h0x, h0y, h1x, h1y, h2x, h2y, bx, by;
    logic [11:0] exp_c, got_c, bexp, bgot;
    logic        exp_h, exp_v;
    int          ticks = 0, valid = 1, bad = 0, lit = 0, guard = 0;
    px = x; py = y; h0x = x; h0y = y; h1x = '0; h1y = '0; h2x = '0; h2y = '0;
    bx = '0; by = '0; bexp = '0; bgot = '0;
    while (ticks < H_TOTAL * V_TOTAL + 1 && guard < CLK_DIV * (H_TOTAL * V_TOTAL + 4)) begin
      @(negedge clk);
      guard++;
      if (x !== px || y !== py) begin
        ticks++;
        h2x = h1x; h2y = h1y; h1x = h0x; h1y = h0y; h0x = x; h0y = y;
        px = x; py = y;
        valid++;
        if (valid >= 3) begin
          exp_c = (h2x < H_ACTIVE && h2y < V_ACTIVE) ? {h2x[3:0], h2y[3:0], 4'hA} : 12'h000;
          exp_h = !(h2x >= 656 && h2x < 752);
          exp_v = !(h2y >= V_ACTIVE + V_FP && h2y < V_ACTIVE + V_FP + V_SYNC);
          got_c = {vga_r, vga_g, vga_b};
          if (got_c !== 12'h000) lit++;
          if (got_c !== exp_c || hsync !== exp_h || vsync !== exp_v) begin
            if (bad == 0) begin bx = h2x; by = h2y; bexp = exp_c; bgot = got_c; end
            bad++;
          end
        end
      end
    end
    checks++; if (ticks != H_TOTAL * V_TOTAL + 1) begin failures++; $display("FAIL color_ticks: got %0d ticks expected %0d", ticks, H_TOTAL * V_TOTAL + 1); end
    checks++; if (bad != 0) begin failures++; $display("FAIL color_align: got %0d mismatches (first x=%0d y=%0d rgb=%h) expected 0 (rgb=%h)", bad, bx, by, bgot, bexp); end
    checks++; if (lit != H_ACTIVE * V_ACTIVE) begin failures++; $display("FAIL color_lit_count: got %0d lit pixels expected %0d", lit, H_ACTIVE * V_ACTIVE); end
  endtask

  task automatic test_hsync();
    bit          ok;
    int          n;
    logic [15:0] px;
    int unsigned t0;
    wait_xy(656, 0, 2 * FRAME_CLKS, ok);
    checks++; if (!ok) begin failures++; $display("FAIL hsync_wait: got timeout expected x=656 y=0"); end
    n = 0; px = x;
    for (int i = 0; i < 64 && hsync !== 1'b0; i++) begin
      @(negedge clk);
      if (x !== px) begin n++; px = x; end
    end
    checks++; if (hsync !== 1'b0 || n != LAT) begin failures++; $display("FAIL hsync_fall: got fall %0d ticks after x=656 (hs=%b) expected %0d", n, hsync, LAT); end
    t0 = cyc; n = 0;
    for (int i = 0; i < 1000 && hsync !== 1'b1; i++) begin
      @(negedge clk);
      if (x !== px) begin n++; px = x; end
    end
    checks++; if (n != 96) begin failures++; $display("FAIL hsync_width: got %0d ticks expected 96", n); end
    for (int i = 0; i < 4000 && hsync !== 1'b0; i++) @(negedge clk);
    checks++; if (cyc - t0 != LINE_CLKS) begin failures++; $display("FAIL line_period: got %0d clocks expected %0d", cyc - t0, LINE_CLKS); end
  endtask

  task automatic test_vsync();
    bit          ok;
    int          n;
    logic [15:0] px;
    int unsigned t0;
    wait_xy(0, V_ACTIVE + V_FP, 2 * FRAME_CLKS, ok);
    checks++; if (!ok) begin failures++; $display("FAIL vsync_wait: got timeout expected x=0 y=%0d", V_ACTIVE + V_FP); end
    n = 0; px = x;
    for (int i = 0; i < 64 && vsync !== 1'b0; i++) begin
      @(negedge clk);
      if (x !== px) begin n++; px = x; end
    end
    checks++; if (vsync !== 1'b0 || n != LAT) begin failures++; $display("FAIL vsync_fall: got fall %0d ticks after line start (vs=%b) expected %0d", n, vsync, LAT); end
    t0 = cyc;
    for (int i = 0; i < 4 * LINE_CLKS && vsync !== 1'b1; i++) @(negedge clk);
    checks++; if (cyc - t0 != V_SYNC * LINE_CLKS) begin failures++; $display("FAIL vsync_width: got %0d clocks expected %0d", cyc - t0, V_SYNC * LINE_CLKS); end
  endtask

  task automatic test_frame_start();
    int unsigned t0;
    for (int i = 0; i < FRAME_CLKS + 16 && frame_start !== 1'b1; i++) @(negedge clk);
    checks++; if (frame_start !== 1'b1 || x !== 16'd0 || y !== 16'd0) begin failures++; $display("FAIL frame_start_pos: got fs=%b x=%0d y=%0d expected 1 0 0", frame_start, x, y); end
    t0 = cyc;
    @(negedge clk);
    checks++; if (frame_start !== 1'b0) begin failures++; $display("FAIL frame_start_width: got %b one clock later expected 0", frame_start); end
    for (int i = 0; i < FRAME_CLKS + 16 && frame_start !== 1'b1; i++) @(negedge clk);
    checks++; if (cyc - t0 != FRAME_CLKS) begin failures++; $display("FAIL frame_period: got %0d clocks expected %0d", cyc - t0, FRAME_CLKS); end
  endtask

  task automatic test_reset_midframe();
    bit ok;
    int n, first_x;
    wait_xy(300, 0, 2 * FRAME_CLKS, ok);
    checks++; if (!ok || {vga_r, vga_g, vga_b} !== 12'hA0A) begin failures++; $display("FAIL midframe_pre: got ok=%b rgb=%h expected 1 A0A", ok, {vga_r, vga_g, vga_b}); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (x !== 16'd0 || y !== 16'd0) begin failures++; $display("FAIL midframe_xy: got x=%0d y=%0d expected 0 0", x, y); end
    checks++; if (hsync !== 1'b1 || vsync !== 1'b1 || {vga_r, vga_g, vga_b} !== 12'h000) begin failures++; $display("FAIL midframe_out: got hs=%b vs=%b rgb=%h expected 1 1 000", hsync, vsync, {vga_r, vga_g, vga_b}); end
    rst = 1'b0;
    n = 0; first_x = 0;
    for (int i = 0; i < FRAME_CLKS + 16 && frame_start !== 1'b1; i++) begin
      @(negedge clk);
      n++;
      if (first_x == 0 && x == 16'd1) first_x = n;
    end
    checks++; if (first_x != CLK_DIV) begin failures++; $display("FAIL midframe_first_tick: got %0d clocks expected %0d", first_x, CLK_DIV); end
    checks++; if (frame_start !== 1'b1 || n != FRAME_CLKS) begin failures++; $display("FAIL midframe_frame_start: got %0d clocks (fs=%b) expected %0d", n, frame_start, FRAME_CLKS); end
  endtask

`ifdef VGA_TEST_PATTERN_EN
  task automatic test_pattern();
    int          vx  [7] = '{0, 69, 128, 256, 384, 512, 640};
    bit          ven [7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [11:0] vexp[7] = '{12'hFFF, 12'h50A, 12'hFF0, 12'h0FF, 12'h0F0, 12'hF0F, 12'h000};
    bit          ok;
    int          n;
    logic [15:0] px;
    for (int v = 0; v < 7; v++) begin
      test_en = ven[v];
      wait_xy(vx[v], 0, 2 * FRAME_CLKS, ok);
      n = 0; px = x;
      for (int i = 0; i < 64 && n < LAT; i++) begin
        @(negedge clk);
        if (x !== px) begin n++; px = x; end
      end
      checks++; if (!ok || {vga_r, vga_g, vga_b} !== vexp[v]) begin failures++; $display("FAIL pattern_x%0d_en%0d: got %h (ok=%b) expected %h", vx[v], ven[v], {vga_r, vga_g, vga_b}, ok, vexp[v]); end
    end
    test_en = 1'b0;
  endtask
`endif

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
`ifdef VGA_TEST_PATTERN_EN
    test_en = 1'b0;
`endif
    @(negedge clk);
    test_reset();
    test_color_align();
    test_hsync();
    test_vsync();
    test_frame_start();
    test_reset_midframe();
`ifdef VGA_TEST_PATTERN_EN
    test_pattern();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
